// File: rtl/product_sequencer.sv
// ---------------------------------------------------------------------------
// product_sequencer
//
// Front-end sequencer for the nibble-fed product datapath. Two WIDTH-bit
// operands arrive most-significant nibble first over a valid/ready nibble
// bus. A bit-serial shift-add multiply then runs for WIDTH cycles. The
// 2*WIDTH-bit product is presented one byte at a time, most-significant
// byte first. Each rising edge of `read` steps to the next byte.
//
// Configuration macro: PRODUCT_SIGNED_EN
//   defined   -> operands and product are two's complement
//   undefined -> unsigned operands and product
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   nib_valid  host presents an operand nibble
//   nibble     operand nibble, most-significant nibble first
//   nib_ready  nibble accepted on this cycle's edge when nib_valid is high
//   read       rising edge advances the output byte while done is high
//   abort      synchronous soft clear, active-high
//   result     current product byte, 0x00 outside the output phase
//   busy       multiply in progress
//   done       product available on result
// ---------------------------------------------------------------------------
module product_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nib_valid,
    input  logic [3:0] nibble,
    output logic       nib_ready,
    input  logic       read,
    input  logic       abort,
    output logic [7:0] result,
    output logic       busy,
    output logic       done
);

    localparam int NPO = WIDTH / 4;       // nibbles per operand
    localparam int NPB = WIDTH / 4;       // product bytes
    localparam int PW  = 2 * WIDTH;       // product width
    localparam int CW  = $clog2(WIDTH);   // nibble / multiplier-bit counter
    localparam int KW  = 2;               // byte index, NPB <= 4

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        MUL,
        OUT
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;       // loads operand B, then shifts right as the multiplier
    logic [PW-1:0]     mcand_reg;   // multiplicand, shifted left once per multiply cycle
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     prod_reg;    // current output byte always sits in the top 8 bits
    logic [CW-1:0]     cnt_reg;
    logic [KW-1:0]     k_reg;
    logic              read_q;
    logic              nib_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [7:0]        result_reg;
`ifdef PRODUCT_SIGNED_EN
    logic              sign_reg;
`endif

    logic [WIDTH-1:0]  a_next;
    logic [WIDTH-1:0]  b_next;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     prod_final;
    logic [PW-1:0]     prod_shift;
    logic              accept;
    logic              read_rise;

`ifdef PRODUCT_SIGNED_EN
    // Magnitude of a two's complement value; the most-negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction
`endif

    always_comb begin
        a_next     = (a_reg << 4) | WIDTH'(nibble);
        b_next     = (b_reg << 4) | WIDTH'(nibble);
        acc_next   = acc_reg + (b_reg[0] ? mcand_reg : '0);
`ifdef PRODUCT_SIGNED_EN
        prod_final = sign_reg ? (~acc_next + PW'(1)) : acc_next;
`else
        prod_final = acc_next;
`endif
        prod_shift = prod_reg << 8;
        accept     = nib_valid & nib_ready_reg;
        read_rise  = read & ~read_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= LOAD_A;
            a_reg         <= '0;
            b_reg         <= '0;
            mcand_reg     <= '0;
            acc_reg       <= '0;
            prod_reg      <= '0;
            cnt_reg       <= '0;
            k_reg         <= '0;
            read_q        <= 1'b0;
            nib_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= 8'h00;
`ifdef PRODUCT_SIGNED_EN
            sign_reg      <= 1'b0;
`endif
        end else begin
            // The edge detector keeps tracking read in every state, abort included.
            read_q <= read;
            if (abort) begin
                state_reg     <= LOAD_A;
                a_reg         <= '0;
                b_reg         <= '0;
                mcand_reg     <= '0;
                acc_reg       <= '0;
                prod_reg      <= '0;
                cnt_reg       <= '0;
                k_reg         <= '0;
                nib_ready_reg <= 1'b1;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b0;
                result_reg    <= 8'h00;
`ifdef PRODUCT_SIGNED_EN
                sign_reg      <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    LOAD_A: begin
                        if (accept) begin
                            a_reg <= a_next;
                            if (cnt_reg == CW'(NPO - 1)) begin
                                cnt_reg   <= '0;
                                state_reg <= LOAD_B;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                    end
                    LOAD_B: begin
                        if (accept) begin
                            if (cnt_reg == CW'(NPO - 1)) begin
                                // Last nibble: operand B is complete this edge,
                                // so the multiplier is seeded from b_next.
                                cnt_reg       <= '0;
                                state_reg     <= MUL;
                                nib_ready_reg <= 1'b0;
                                busy_reg      <= 1'b1;
                                acc_reg       <= '0;
`ifdef PRODUCT_SIGNED_EN
                                mcand_reg     <= PW'(mag(a_reg));
                                b_reg         <= mag(b_next);
                                sign_reg      <= a_reg[WIDTH-1] ^ b_next[WIDTH-1];
`else
                                mcand_reg     <= PW'(a_reg);
                                b_reg         <= b_next;
`endif
                            end else begin
                                b_reg   <= b_next;
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                    end
                    MUL: begin
                        acc_reg   <= acc_next;
                        mcand_reg <= mcand_reg << 1;
                        b_reg     <= b_reg >> 1;
                        if (cnt_reg == CW'(WIDTH - 1)) begin
                            cnt_reg    <= '0;
                            k_reg      <= '0;
                            state_reg  <= OUT;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                            prod_reg   <= prod_final;
                            result_reg <= prod_final[PW-1 -: 8];
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    OUT: begin
                        if (read_rise) begin
                            if (k_reg == KW'(NPB - 1)) begin
                                k_reg         <= '0;
                                state_reg     <= LOAD_A;
                                done_reg      <= 1'b0;
                                nib_ready_reg <= 1'b1;
                                result_reg    <= 8'h00;
                            end else begin
                                k_reg      <= k_reg + KW'(1);
                                prod_reg   <= prod_shift;
                                result_reg <= prod_shift[PW-1 -: 8];
                            end
                        end
                    end
                    default: state_reg <= LOAD_A;
                endcase
            end
        end
    end

    assign nib_ready = nib_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_product_sequencer.sv
// ---------------------------------------------------------------------------
// tb_product_sequencer
//
// Self-checking bench for product_sequencer at WIDTH=8. Expected products
// come from plain integer multiplication (signed when PRODUCT_SIGNED_EN is
// defined). Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_product_sequencer;

    localparam int W   = 8;
    localparam int NPO = W / 4;
    localparam int NPB = W / 4;
    localparam int PW  = 2 * W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nib_valid = 1'b0;
    logic [3:0] nibble = 4'h0;
    logic       read = 1'b0;
    logic       abort = 1'b0;
    logic       nib_ready;
    logic [7:0] result;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    product_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .nib_valid (nib_valid),
        .nibble    (nibble),
        .nib_ready (nib_ready),
        .read      (read),
        .abort     (abort),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: the full product from integer arithmetic.
    function automatic logic [PW-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
`ifdef PRODUCT_SIGNED_EN
        sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
        sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return PW'(sa * sb);
    endfunction

    function automatic logic [7:0] model_byte(input logic [PW-1:0] p, input int k);
        logic [PW-1:0] t;
        t = p >> (8 * (NPB - 1 - k));
        return t[7:0];
    endfunction

    // Stimulus: present all nibbles of A then B, optionally with idle gaps.
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input bit gaps);
        logic [W-1:0] op;
        logic [W-1:0] t;
        int g;
        for (int j = 0; j < 2 * NPO; j++) begin
            op = (j < NPO) ? a : b;
            t  = op >> (4 * (NPO - 1 - (j % NPO)));
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    nib_valid = 1'b0;
                    nibble    = 4'($urandom);
                    @(negedge clk);
                end
            end
            nib_valid = 1'b1;
            nibble    = t[3:0];
            @(negedge clk);
        end
        nib_valid = 1'b0;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for done; returns the number of cycles waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({nib_ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b done=%b res=%02h expected rdy=1 busy=0 done=0 res=00",
                     nib_ready, busy, done, result);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("reset: rdy=%b busy=%b done=%b res=%02h", nib_ready, busy, done, result);
    endtask

    task automatic test_basic();
        logic [PW-1:0] p;
        logic [7:0] exp;
        p = model_product(8'h0D, 8'h0B);
        feed(8'h0D, 8'h0B, 1'b0);
        checks++;
        if ({nib_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL basic_enter_mul: got rdy=%b busy=%b expected rdy=0 busy=1", nib_ready, busy);
        end
        repeat (W - 1) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_early: got done=%b expected 0 at cycle %0d", done, W - 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_latency: got done=%b expected 1 at cycle %0d", done, W);
        end
        for (int k = 0; k < NPB; k++) begin
            exp = model_byte(p, k);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL basic_byte%0d: got %02h expected %02h", k, result, exp);
            end
            pulse_read();
        end
        checks++;
        if ({nib_ready, done, result} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL basic_exit: got rdy=%b done=%b res=%02h expected rdy=1 done=0 res=00",
                     nib_ready, done, result);
        end
        $display("basic: 0D x 0B product %04h", p);
    endtask

    task automatic test_toggle();
        logic [PW-1:0] p;
        logic [7:0] exp;
        int accepts;
        p = model_product(8'hFF, 8'hFF);
        accepts = 0;
        for (int c = 0; c < 16; c++) begin
            nib_valid = (c % 2 == 0);
            nibble    = 4'hF;
            if (nib_valid && nib_ready) accepts++;
            @(negedge clk);
        end
        nib_valid = 1'b0;
        checks++;
        if (accepts !== 2 * NPO || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_accepts: got accepts=%0d done=%b expected accepts=%0d done=1",
                     accepts, done, 2 * NPO);
        end
        for (int k = 0; k < NPB; k++) begin
            exp = model_byte(p, k);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL toggle_byte%0d: got %02h expected %02h", k, result, exp);
            end
            pulse_read();
        end
        $display("toggle: FF x FF product %04h, %0d accepts", p, accepts);
    endtask

    task automatic test_read_hold();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [PW-1:0] p;
        logic [7:0] exp;
        int cyc;
        a = W'($urandom);
        b = W'($urandom);
        p = model_product(a, b);
        feed(a, b, 1'b0);
        // Garbage nibbles during MUL and OUT must be dropped.
        nib_valid = 1'b1;
        cyc = 0;
        while (!done && cyc < 64) begin
            nibble = 4'($urandom);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL hold_latency: got %0d cycles expected %0d", cyc, W);
        end
        read = 1'b1;
        repeat (5) begin
            nibble = 4'($urandom);
            @(negedge clk);
        end
        exp = model_byte(p, 1);
        checks++;
        if (result !== exp || done !== 1'b1) begin
            errors++;
            $display("FAIL hold_single_advance: got res=%02h done=%b expected res=%02h done=1", result, done, exp);
        end
        read = 1'b0;
        nib_valid = 1'b0;
        @(negedge clk);
        for (int k = 1; k < NPB; k++) pulse_read();
        checks++;
        if ({nib_ready, result} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL hold_exit: got rdy=%b res=%02h expected rdy=1 res=00", nib_ready, result);
        end
        // The next product must be built only from freshly fed nibbles.
        a = W'($urandom);
        b = W'($urandom);
        p = model_product(a, b);
        feed(a, b, 1'b0);
        wait_done(cyc);
        for (int k = 0; k < NPB; k++) begin
            exp = model_byte(p, k);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL hold_next_byte%0d: got %02h expected %02h", k, result, exp);
            end
            pulse_read();
        end
        $display("read_hold: next product %02h x %02h = %04h", a, b, p);
    endtask

    task automatic test_reset_mul();
        logic [PW-1:0] p;
        logic [7:0] exp;
        int cyc;
        feed(8'h5A, 8'hC3, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({nib_ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mul_reset: got rdy=%b busy=%b done=%b res=%02h expected rdy=1 busy=0 done=0 res=00",
                     nib_ready, busy, done, result);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        p = model_product(8'h02, 8'h03);
        feed(8'h02, 8'h03, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL mul_reset_latency: got %0d cycles expected %0d", cyc, W);
        end
        for (int k = 0; k < NPB; k++) begin
            exp = model_byte(p, k);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL mul_reset_byte%0d: got %02h expected %02h", k, result, exp);
            end
            pulse_read();
        end
        $display("reset_mul: 02 x 03 product %04h", p);
    endtask

    task automatic test_abort();
        logic [PW-1:0] p;
        logic [7:0] exp;
        int cyc;
        // A complete, then one nibble of B.
        feed(8'h37, 8'h00, 1'b0);
        nib_valid = 1'b0;
        // That feed finished both operands; start a fresh partial load instead.
        wait_done(cyc);
        for (int k = 0; k < NPB; k++) pulse_read();
        for (int j = 0; j < NPO + 1; j++) begin
            nib_valid = 1'b1;
            nibble    = 4'h5;
            @(negedge clk);
        end
        // Abort with a competing nibble: the abort must win.
        abort     = 1'b1;
        nib_valid = 1'b1;
        nibble    = 4'hF;
        @(negedge clk);
        abort     = 1'b0;
        nib_valid = 1'b0;
        checks++;
        if ({nib_ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL abort_state: got rdy=%b busy=%b done=%b res=%02h expected rdy=1 busy=0 done=0 res=00",
                     nib_ready, busy, done, result);
        end
        p = model_product(8'h10, 8'h10);
        feed(8'h10, 8'h10, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL abort_latency: got %0d cycles expected %0d", cyc, W);
        end
        for (int k = 0; k < NPB; k++) begin
            exp = model_byte(p, k);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL abort_byte%0d: got %02h expected %02h", k, result, exp);
            end
            pulse_read();
        end
        $display("abort: 10 x 10 product %04h", p);
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [PW-1:0] p;
        logic [7:0] exp;
        int cyc;
        for (int i = 0; i < n + 2; i++) begin
            // First two entries are the sign-sensitive corner cases.
            if (i == 0) begin
                a = 8'hFF;
                b = 8'h02;
            end else if (i == 1) begin
                a = 8'h80;
                b = 8'h80;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            p = model_product(a, b);
            feed(a, b, 1'b1);
            wait_done(cyc);
            checks++;
            if (cyc !== W) begin
                errors++;
                $display("FAIL rand%0d_latency: got %0d cycles expected %0d", i, cyc, W);
            end
            for (int k = 0; k < NPB; k++) begin
                exp = model_byte(p, k);
                checks++;
                if (result !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d: %02h x %02h got %02h expected %02h", i, k, a, b, result, exp);
                end
                pulse_read();
            end
            $display("rand%0d: %02h x %02h = %04h", i, a, b, p);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_read_hold();
        test_reset_mul();
        test_abort();
        test_random(16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
